note_tone_generator: RTL and testbench

- Downstream of the ASCII-to-note converter. Consumes its 5-bit note index: 0 means silence, 1..21 are three C-major octaves.
- Produces a 50%-duty square wave on `tone_out` for the buzzer/speaker pin.
- Note changes and stops take effect only at whole-period boundaries, so the waveform never has a runt or glitched half-cycle.
- Also reports the note currently sounding, for display logic.

---
 rtl/note_tone_generator.sv | 113 +++++++++++
 tb/tb_note_tone_generator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/note_tone_generator.sv
// Square-wave tone generator for a 5-bit note index (0 = silence, 1..21 = C4..B6).
// Note changes and releases are sampled only at the end of a LOW phase, so every period is whole.
module note_tone_generator #(
  parameter int CLK_HZ = 100_000_000,
  parameter int CNT_W  = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] note_in,
  output logic       tone_out,
  output logic       playing,
  output logic [4:0] cur_note
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  // Half-period length in clock cycles for each note; elaborates to constants.
  function automatic logic [CNT_W-1:0] half_of(input logic [4:0] n);
    case (n)
      5'd1:    half_of = CNT_W'(CLK_HZ / (2 * 262));
      5'd2:    half_of = CNT_W'(CLK_HZ / (2 * 294));
      5'd3:    half_of = CNT_W'(CLK_HZ / (2 * 330));
      5'd4:    half_of = CNT_W'(CLK_HZ / (2 * 349));
      5'd5:    half_of = CNT_W'(CLK_HZ / (2 * 392));
      5'd6:    half_of = CNT_W'(CLK_HZ / (2 * 440));
      5'd7:    half_of = CNT_W'(CLK_HZ / (2 * 494));
      5'd8:    half_of = CNT_W'(CLK_HZ / (2 * 523));
      5'd9:    half_of = CNT_W'(CLK_HZ / (2 * 587));
      5'd10:   half_of = CNT_W'(CLK_HZ / (2 * 659));
      5'd11:   half_of = CNT_W'(CLK_HZ / (2 * 698));
      5'd12:   half_of = CNT_W'(CLK_HZ / (2 * 784));
      5'd13:   half_of = CNT_W'(CLK_HZ / (2 * 880));
      5'd14:   half_of = CNT_W'(CLK_HZ / (2 * 988));
      5'd15:   half_of = CNT_W'(CLK_HZ / (2 * 1047));
      5'd16:   half_of = CNT_W'(CLK_HZ / (2 * 1175));
      5'd17:   half_of = CNT_W'(CLK_HZ / (2 * 1319));
      5'd18:   half_of = CNT_W'(CLK_HZ / (2 * 1397));
      5'd19:   half_of = CNT_W'(CLK_HZ / (2 * 1568));
      5'd20:   half_of = CNT_W'(CLK_HZ / (2 * 1760));
      5'd21:   half_of = CNT_W'(CLK_HZ / (2 * 1976));
      default: half_of = '0;
    endcase
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] half_reg;
  logic             note_valid;
  logic             phase_end;

  assign note_valid = (note_in != 5'd0) && (note_in <= 5'd21);
  assign phase_end  = (cnt == half_reg - CNT_W'(1));
  assign playing    = (state != S_IDLE);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      half_reg <= '0;
      cur_note <= 5'd0;
      tone_out <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (note_valid) begin
            cur_note <= note_in;
            half_reg <= half_of(note_in);
            cnt      <= '0;
            tone_out <= 1'b1;
            state    <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (phase_end) begin
            cnt      <= '0;
            tone_out <= 1'b0;
            state    <= S_LOW;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_LOW: begin
          if (!phase_end) begin
            cnt <= cnt + CNT_W'(1);
          end else if (note_valid) begin
            cur_note <= note_in;
            half_reg <= half_of(note_in);
            cnt      <= '0;
            tone_out <= 1'b1;
            state    <= S_HIGH;
          end else begin
            cur_note <= 5'd0;
            half_reg <= '0;
            cnt      <= '0;
            tone_out <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: begin
          cur_note <= 5'd0;
          half_reg <= '0;
          cnt      <= '0;
          tone_out <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_generator.sv
// Bench for note_tone_generator at CLK_HZ = 1 MHz: a phase-countdown model checked every cycle,
// plus directed measurements of high/low phase lengths against hand-computed half periods.
module tb_note_tone_generator;

  localparam int CLK_HZ = 1_000_000;
  localparam int CNT_W  = 24;
  localparam int BUDGET = 5000;

  logic       clk;
  logic       rst;
  logic [4:0] note_in;
  logic       tone_out;
  logic       playing;
  logic [4:0] cur_note;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;

  note_tone_generator #(.CLK_HZ(CLK_HZ), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .note_in  (note_in),
    .tone_out (tone_out),
    .playing  (playing),
    .cur_note (cur_note)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a note's half period follows directly from its frequency in Hz.
  int freq_hz [21] = '{262, 294, 330, 349, 392, 440, 494,
                       523, 587, 659, 698, 784, 880, 988,
                       1047, 1175, 1319, 1397, 1568, 1760, 1976};

  function automatic bit is_note(input logic [4:0] n);
    return (n >= 5'd1) && (n <= 5'd21);
  endfunction

  function automatic int half_cycles(input logic [4:0] n);
    return CLK_HZ / (2 * freq_hz[int'(n) - 1]);
  endfunction

  bit   m_play;
  bit   m_tone;
  int   m_note;
  int   m_left;

  // Model tracks the cycles remaining in the current half period.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_play <= 1'b0;
      m_tone <= 1'b0;
      m_note <= 0;
      m_left <= 0;
    end else if (!m_play) begin
      if (is_note(note_in)) begin
        m_play <= 1'b1;
        m_tone <= 1'b1;
        m_note <= int'(note_in);
        m_left <= half_cycles(note_in);
      end
    end else if (m_left > 1) begin
      m_left <= m_left - 1;
    end else if (m_tone) begin
      m_tone <= 1'b0;
      m_left <= half_cycles(5'(m_note));
    end else if (is_note(note_in)) begin
      m_tone <= 1'b1;
      m_note <= int'(note_in);
      m_left <= half_cycles(note_in);
    end else begin
      m_play <= 1'b0;
      m_tone <= 1'b0;
      m_note <= 0;
      m_left <= 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_tone_out", int'(tone_out), int'(m_tone));
      check("cyc_playing", int'(playing), int'(m_play));
      check("cyc_cur_note", int'(cur_note), m_note);
    end
  end

  // Counts negedges on which tone_out stays at lvl while playing; starts on such a negedge.
  task automatic run_len(input logic lvl, output int n);
    n = 0;
    while (tone_out == lvl && playing && n < BUDGET) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    rst     = 1'b1;
    note_in = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_tone_out", int'(tone_out), 0);
    check("reset_playing", int'(playing), 0);
    check("reset_cur_note", int'(cur_note), 0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Out-of-range index is silence.
    note_in = 5'd25;
    repeat (20) @(negedge clk);
    check("invalid_tone_out", int'(tone_out), 0);
    check("invalid_playing", int'(playing), 0);
    note_in = 5'd0;
    @(negedge clk);

    // Single note A4.
    note_in = 5'd6;
    @(negedge clk);
    check("first_edge_rise", int'(tone_out), 1);
    check("a4_cur_note", int'(cur_note), 6);
    check("a4_playing", int'(playing), 1);
    run_len(1'b1, n); check("a4_high_len", n, 1136);
    run_len(1'b0, n); check("a4_low_len", n, 1136);

    // Mid-period change to C5 after 300 HIGH cycles.
    repeat (300) @(negedge clk);
    note_in = 5'd8;
    run_len(1'b1, n);
    check("chg_cur_note_low", int'(cur_note), 6);
    run_len(1'b0, n); check("chg_low_len", n, 1136);
    check("chg_cur_note_new", int'(cur_note), 8);
    run_len(1'b1, n); check("c5_high_len", n, 956);
    note_in = 5'd6;
    run_len(1'b0, n); check("c5_low_len", n, 956);

    // Glitch to 0 for 10 cycles inside HIGH of A4.
    check("glitch_cur_note", int'(cur_note), 6);
    repeat (100) @(negedge clk);
    note_in = 5'd0;
    repeat (10) @(negedge clk);
    note_in = 5'd6;
    run_len(1'b1, n); check("glitch_high_rest", n, 1026);
    run_len(1'b0, n); check("glitch_low_len", n, 1136);
    check("glitch_still_playing", int'(playing), 1);

    // Release: the current period completes, then idle.
    note_in = 5'd0;
    run_len(1'b1, n); check("rel_high_len", n, 1136);
    run_len(1'b0, n); check("rel_low_len", n, 1136);
    check("rel_playing", int'(playing), 0);
    check("rel_tone_out", int'(tone_out), 0);
    check("rel_cur_note", int'(cur_note), 0);
    repeat (5) @(negedge clk);

    // One-cycle tap still yields one full period.
    note_in = 5'd6;
    @(negedge clk);
    note_in = 5'd0;
    check("tap_rise", int'(tone_out), 1);
    run_len(1'b1, n); check("tap_high_len", n, 1136);
    run_len(1'b0, n); check("tap_low_len", n, 1136);
    check("tap_idle", int'(playing), 0);
    repeat (5) @(negedge clk);

    // Extremes: C4 then B6.
    note_in = 5'd1;
    @(negedge clk);
    run_len(1'b1, n); check("c4_high_len", n, 1908);
    run_len(1'b0, n); check("c4_low_len", n, 1908);
    note_in = 5'd21;
    run_len(1'b1, n); check("c4_high_len2", n, 1908);
    run_len(1'b0, n); check("c4_low_len2", n, 1908);
    check("b6_cur_note", int'(cur_note), 21);
    run_len(1'b1, n); check("b6_high_len", n, 253);
    run_len(1'b0, n); check("b6_low_len", n, 253);
    note_in = 5'd0;
    run_len(1'b1, n); check("b6_high_len2", n, 253);
    run_len(1'b0, n); check("b6_low_len2", n, 253);
    check("b6_idle", int'(playing), 0);

    // Asynchronous reset mid-tone, observed before the next clock edge.
    note_in = 5'd6;
    repeat (50) @(negedge clk);
    check("pre_rst_tone_out", int'(tone_out), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_tone_out", int'(tone_out), 0);
    check("async_rst_playing", int'(playing), 0);
    check("async_rst_cur_note", int'(cur_note), 0);
    @(negedge clk);
    note_in = 5'd0;
    rst     = 1'b0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", int'(playing), 0);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
